// File: rtl/qpsk_pkg.sv
// Shared types and sizing helpers for the QPSK receiver's BER checker.
package qpsk_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int lat_w(input int max_delay);
    return $clog2(max_delay);
  endfunction

  // Wide enough to hold the value WINDOW itself, not just WINDOW-1.
  function automatic int win_w(input int window);
    return $clog2(window + 1);
  endfunction

  localparam int LAT_W = lat_w(512);
  localparam int WIN_W = win_w(511);

endpackage

// File: rtl/ber_delay_line.sv
// Reference-bit delay line: DEPTH-1 registers plus the live input form DEPTH taps,
// and a variable tap mux picks the bit delayed by sel enables.
module ber_delay_line #(
  parameter int DEPTH = 512,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  output logic             tap
);

  logic [DEPTH-2:0] line;
  logic [DEPTH-1:0] taps;

  assign taps = {line, din};

  // Shift register; cleared by rst only, so a soft clear keeps the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (enable) begin
      line <= taps[DEPTH-2:0];
    end
  end

  // Tap select; out-of-range selects are unreachable but read as zero.
  always_comb begin
    tap = 1'b0;
    if (32'(sel) < DEPTH) begin
      tap = taps[sel];
    end else begin
      tap = 1'b0;
    end
  end

endmodule

// File: rtl/ber_checker.sv
// BER checker: sweeps the reference delay to find the channel latency, locks on
// the minimum-error delay and counts bits/errors. Optional relock: BER_RELOCK_EN.
module ber_checker
  import qpsk_pkg::*;
#(
  parameter int MAX_DELAY  = 512,
  parameter int WINDOW     = 511,
  parameter int CNT_W      = 64,
  parameter int RELOCK_THR = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_enable,
  input  logic                         i_ref_bit,
  input  logic                         i_rx_bit,
  input  logic                         i_clear,
  output logic                         o_locked,
  output logic [$clog2(MAX_DELAY)-1:0] o_latency,
  output logic [CNT_W-1:0]             o_bit_count,
  output logic [CNT_W-1:0]             o_err_count
);

  localparam int LW = lat_w(MAX_DELAY);
  localparam int WW = win_w(WINDOW);
  localparam int BW = WW + 1;
  localparam logic [LW-1:0] K_LAST   = LW'(MAX_DELAY - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t          state, state_nxt;
  logic [LW-1:0]   k, k_nxt;
  logic [LW-1:0]   best_k, best_k_nxt;
  logic [LW-1:0]   lat_nxt;
  logic [WW-1:0]   win_cnt, win_cnt_nxt;
  logic [WW-1:0]   win_err, win_err_nxt, win_err_sum;
  logic [BW-1:0]   best_err, best_err_nxt;
  logic            locked_nxt;
  logic [CNT_W-1:0] bit_nxt, err_nxt;
  logic [LW-1:0]   tap_sel;
  logic            tap;
  logic            err_bit;
  logic            relock;

  assign tap_sel     = (state == LOCKED) ? o_latency : k;
  assign err_bit     = i_rx_bit ^ tap;
  assign win_err_sum = win_err + WW'(err_bit);

  ber_delay_line #(
    .DEPTH(MAX_DELAY),
    .SEL_W(LW)
  ) u_dly (
    .clk   (clk),
    .rst   (rst),
    .enable(i_enable),
    .din   (i_ref_bit),
    .sel   (tap_sel),
    .tap   (tap)
  );

`ifdef BER_RELOCK_EN
  logic [WW-1:0] lwin_cnt, lwin_err, lwin_err_sum;

  assign lwin_err_sum = lwin_err + WW'(err_bit);
  assign relock = i_enable && (state == LOCKED) && (lwin_cnt == WIN_LAST) &&
                  (32'(lwin_err_sum) >= 32'(RELOCK_THR));

  // Error window on the locked tap; idle outside LOCKED.
  always_ff @(posedge clk) begin
    if (rst || i_clear || relock || (state != LOCKED)) begin
      lwin_cnt <= '0;
      lwin_err <= '0;
    end else if (i_enable) begin
      if (lwin_cnt == WIN_LAST) begin
        lwin_cnt <= '0;
        lwin_err <= '0;
      end else begin
        lwin_cnt <= lwin_cnt + WW'(1);
        lwin_err <= lwin_err_sum;
      end
    end
  end
`else
  assign relock = 1'b0;
`endif

  // Next-state and counter updates for one enabled symbol.
  always_comb begin
    state_nxt    = state;
    k_nxt        = k;
    best_k_nxt   = best_k;
    best_err_nxt = best_err;
    win_cnt_nxt  = win_cnt;
    win_err_nxt  = win_err;
    locked_nxt   = o_locked;
    lat_nxt      = o_latency;
    bit_nxt      = o_bit_count;
    err_nxt      = o_err_count;
    case (state)
      SEARCH: begin
        if (win_cnt == WIN_LAST) begin
          win_cnt_nxt = '0;
          win_err_nxt = '0;
          if (BW'(win_err_sum) < best_err) begin
            best_err_nxt = BW'(win_err_sum);
            best_k_nxt   = k;
          end else begin
            best_err_nxt = best_err;
            best_k_nxt   = best_k;
          end
          if (k == K_LAST) begin
            state_nxt  = LOCKED;
            locked_nxt = 1'b1;
            lat_nxt    = best_k_nxt;
            k_nxt      = '0;
          end else begin
            k_nxt = k + LW'(1);
          end
        end else begin
          win_cnt_nxt = win_cnt + WW'(1);
          win_err_nxt = win_err_sum;
        end
      end
      LOCKED: begin
        bit_nxt = sat_inc(o_bit_count);
        if (err_bit) begin
          err_nxt = sat_inc(o_err_count);
        end else begin
          err_nxt = o_err_count;
        end
      end
      default: begin
        state_nxt = SEARCH;
      end
    endcase
  end

  // State and output registers; rst, clear and relock all restart the search.
  always_ff @(posedge clk) begin
    if (rst || i_clear || relock) begin
      state       <= SEARCH;
      k           <= '0;
      best_k      <= '0;
      best_err    <= '1;
      win_cnt     <= '0;
      win_err     <= '0;
      o_locked    <= 1'b0;
      o_latency   <= '0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else if (i_enable) begin
      state       <= state_nxt;
      k           <= k_nxt;
      best_k      <= best_k_nxt;
      best_err    <= best_err_nxt;
      win_cnt     <= win_cnt_nxt;
      win_err     <= win_err_nxt;
      o_locked    <= locked_nxt;
      o_latency   <= lat_nxt;
      o_bit_count <= bit_nxt;
      o_err_count <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: PRBS9 reference, rx delayed by a known latency.
module tb_ber_checker;

  localparam int MD  = 64;
  localparam int WIN = 127;
  localparam int SEARCH_LEN = MD * WIN;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ref_bit = 1'b0;
  logic       rx_bit = 1'b0;
  logic       rx8_bit = 1'b0;
  logic       clr = 1'b0;
  logic       locked, locked8;
  logic [5:0] latency, latency8;
  logic [63:0] bit_cnt, err_cnt;
  logic [7:0]  bit_cnt8, err_cnt8;

  logic [8:0]  prbs = 9'h1FF;
  logic [63:0] hist = '0;
  int          delay = 37;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  ber_checker #(.MAX_DELAY(MD), .WINDOW(WIN), .CNT_W(64), .RELOCK_THR(10)) dut (
    .clk(clk), .rst(rst), .i_enable(en), .i_ref_bit(ref_bit), .i_rx_bit(rx_bit),
    .i_clear(clr), .o_locked(locked), .o_latency(latency),
    .o_bit_count(bit_cnt), .o_err_count(err_cnt)
  );

  ber_checker #(.MAX_DELAY(MD), .WINDOW(WIN), .CNT_W(8), .RELOCK_THR(10)) dut8 (
    .clk(clk), .rst(rst), .i_enable(en), .i_ref_bit(ref_bit), .i_rx_bit(rx8_bit),
    .i_clear(clr), .o_locked(locked8), .o_latency(latency8),
    .o_bit_count(bit_cnt8), .o_err_count(err_cnt8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One enabled symbol followed by gap-1 idle clocks; called #1 after a clk edge.
  task automatic step(input int gap, input bit inv, input bit inv8);
    logic b, r;
    b = prbs[8] ^ prbs[4];
    r = (delay == 0) ? b : hist[delay-1];
    ref_bit = b;
    rx_bit  = r ^ inv;
    rx8_bit = r ^ inv8;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    hist = {hist[62:0], b};
    prbs = {prbs[7:0], b};
    for (int g = 1; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input int n, input int gap, input bit inv8);
    for (int i = 0; i < n; i++) step(gap, 1'b0, inv8);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_latency", 64'(latency), 64'd0);
    check("rst_bits", bit_cnt, 64'd0);
    check("rst_errs", err_cnt, 64'd0);

    // First search with enable every 4th clock
    run(SEARCH_LEN - 1, 4, 1'b0);
    check("not_locked_early", 64'(locked), 64'd0);
    run(1, 4, 1'b0);
    check("locked", 64'(locked), 64'd1);
    check("latency37", 64'(latency), 64'd37);
    check("lock_bits0", bit_cnt, 64'd0);
    check("lock_errs0", err_cnt, 64'd0);
    check("dut8_latency37", 64'(latency8), 64'd37);

    // 1000 clean locked bits; the 8-bit instance sees every bit wrong
    run(1000, 1, 1'b1);
    check("bits1000", bit_cnt, 64'd1000);
    check("errs0", err_cnt, 64'd0);
    check("sat_bits255", 64'(bit_cnt8), 64'd255);
    check("sat_errs255", 64'(err_cnt8), 64'd255);

    // Enable held low: nothing moves
    repeat (50) @(posedge clk);
    #1;
    check("idle_bits", bit_cnt, 64'd1000);
    check("idle_errs", err_cnt, 64'd0);
    check("idle_latency", 64'(latency), 64'd37);
    check("idle_locked", 64'(locked), 64'd1);

    // Every 100th locked bit inverted
    for (int i = 0; i < 1000; i++) step(1, ((i + 1) % 100) == 0, 1'b0);
    check("bits2000", bit_cnt, 64'd2000);
    check("errs10", err_cnt, 64'd10);

    // Soft clear while locked, then relock at the same latency
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_locked", 64'(locked), 64'd0);
    check("clr_bits", bit_cnt, 64'd0);
    check("clr_errs", err_cnt, 64'd0);
    check("clr_latency", 64'(latency), 64'd0);
    run(SEARCH_LEN - 1, 1, 1'b0);
    check("relock_early", 64'(locked), 64'd0);
    run(1, 1, 1'b0);
    check("relocked", 64'(locked), 64'd1);
    check("relock_latency37", 64'(latency), 64'd37);

    // Reset at candidate 20, channel delay becomes 5
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    run(20 * WIN + 5, 1, 1'b0);
    check("mid_search_unlocked", 64'(locked), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist = '0;
    delay = 5;
    check("mid_rst_latency", 64'(latency), 64'd0);
    run(SEARCH_LEN - 1, 1, 1'b0);
    check("d5_early", 64'(locked), 64'd0);
    run(1, 1, 1'b0);
    check("d5_locked", 64'(locked), 64'd1);
    check("latency5", 64'(latency), 64'd5);
    run(300, 1, 1'b0);
    check("d5_bits", bit_cnt, 64'd300);
    check("d5_errs", err_cnt, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
